dot_seq_ctrl: RTL
=================

Name: dot_seq_ctrl

Overview:
- Sequencer for the DATA_N-lane dot-product unit (main_dotv2).
- On a start pulse it reads IN_CHUNKS beats of input and weight vectors from a pair of synchronous-read buffers and streams them into the dot unit under dot_run.
- It then waits for the dot unit's valid, captures its HID_LENGTH-wide result and reports done.
- A watchdog flags a dot unit that never answers.

Parameters:
- BIT_LENGTH, 16, width of one element
- DATA_N, 6, lanes per beat
- HID_LENGTH, 24, elements in dot result
- IN_CHUNKS, 8, beats per operation (>=1)
- AW, 8, buffer address width
- TIMEOUT, 64, max cycles in WAIT before error (>=1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- base_addr  in  AW  first buffer address; sampled with start
- busy  out  1  high in READ, LAST, WAIT
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag; sticky until next accepted start or rst
- result  out  HID_LENGTH*BIT_LENGTH  last captured dot result
- mem_rd_en  out  1  buffer read enable
- mem_addr  out  AW  buffer read address (shared by data and weight buffers)
- mem_data  in  DATA_N*BIT_LENGTH  data buffer output, valid 1 cycle after rd_en
- mem_wgt  in  DATA_N*BIT_LENGTH  weight buffer output, same timing
- dot_run  out  1  beat-valid strobe to dot unit
- dot_data  out  DATA_N*BIT_LENGTH  data beat to dot unit
- dot_weight  out  DATA_N*BIT_LENGTH  weight beat to dot unit
- dot_valid  in  1  dot unit result valid
- dot_result  in  HID_LENGTH*BIT_LENGTH  dot unit result

Behaviour:
- Reset: state IDLE. busy, done, err, mem_rd_en, dot_run = 0. mem_addr = 0, result = 0, beat counter = 0, timeout counter = 0.
- States and transitions:
  - IDLE: on start, latch base_addr, clear err → READ.
  - READ: lasts exactly IN_CHUNKS cycles. mem_rd_en = 1, mem_addr = latched base + k for k = 0..IN_CHUNKS-1. Address is modulo 2^AW (wraps). Last beat → LAST.
  - LAST: one cycle; carries the final dot_run beat → WAIT.
  - WAIT: timeout counter increments each cycle.
    - dot_valid = 1 → result <= dot_result, → DONE.
    - Counter reaches TIMEOUT without dot_valid → err <= 1, result unchanged, → DONE.
  - DONE: done = 1 for exactly this cycle, busy = 0 → IDLE.
- dot_run is mem_rd_en delayed one cycle: high for exactly IN_CHUNKS consecutive cycles.
- dot_data and dot_weight:
  - While dot_run = 1: combinational pass-through of mem_data and mem_wgt.
  - While dot_run = 0: forced to 0.
- Latency, with start sampled at cycle T:
  - rd_en high T+1..T+IN_CHUNKS.
  - dot_run high T+2..T+IN_CHUNKS+1.
  - WAIT entered at T+IN_CHUNKS+2.
  - dot_valid sampled at cycle V → done at V+1, IDLE at V+2.
- Ignored inputs:
  - start outside IDLE, including during DONE, is ignored; no queuing.
  - dot_valid outside WAIT is ignored and not remembered.
- dot_valid and timeout in the same cycle: valid wins, err stays 0.
- rst mid-operation: next cycle all outputs at reset values and state IDLE. An in-flight result is discarded.
- No arithmetic is done on the data path; widths pass unchanged.

Test Plan:
1. Normal op: preload the buffer.
   - Stimulus: addr0 data {3,5,1,5,8,9} weight {2,5,9,2,3,5}; addr1 data {5,6,1,2,3,4} weight {2,2,4,5,1,2}; 8 beats total. base_addr = 0, start. Dot model asserts valid 3 cycles into WAIT with a known pattern.
   - Required: mem_addr 0..7 on 8 consecutive cycles; dot_run 8 cycles, first beat equals the addr0 vectors; single done pulse; result equals the pattern; err = 0.
2. Wrap-around: AW = 8, base_addr = 250 → addresses 250,251,…,255,0,1; dot_run still 8 contiguous beats.
3. Timeout: TIMEOUT = 16, model never asserts valid → done at WAIT entry + 16; err = 1; result holds previous value. Next start clears err.
4. Start while busy: pulse start during READ, during WAIT and during DONE → no new rd_en burst. Only one done per accepted start.
5. Reset mid-READ: assert rst at beat 4 → next cycle busy = 0, rd_en = 0, dot_run = 0, result = 0. A later start runs a full 8-beat sequence correctly.
6. Spurious/simultaneous valid:
   - dot_valid pulsed during READ → ignored; result updates only on the later valid in WAIT.
   - valid in the same cycle the timeout expires → err = 0, result captured.

Source files
------------

// File: rtl/dot_seq_ctrl_if.sv
// Buffer-read and dot-unit bus between the sequencer (master) and the
// buffer pair plus dot-product unit (slave).
interface dot_seq_ctrl_if #(
  parameter int AW         = 8,
  parameter int DATA_N     = 6,
  parameter int BIT_LENGTH = 16,
  parameter int HID_LENGTH = 24
);
  logic                             mem_rd_en;
  logic [AW-1:0]                    mem_addr;
  logic [DATA_N*BIT_LENGTH-1:0]     mem_data;
  logic [DATA_N*BIT_LENGTH-1:0]     mem_wgt;
  logic                             dot_run;
  logic [DATA_N*BIT_LENGTH-1:0]     dot_data;
  logic [DATA_N*BIT_LENGTH-1:0]     dot_weight;
  logic                             dot_valid;
  logic [HID_LENGTH*BIT_LENGTH-1:0] dot_result;

  modport master (
    output mem_rd_en, mem_addr, dot_run, dot_data, dot_weight,
    input  mem_data, mem_wgt, dot_valid, dot_result
  );

  modport slave (
    input  mem_rd_en, mem_addr, dot_run, dot_data, dot_weight,
    output mem_data, mem_wgt, dot_valid, dot_result
  );
endinterface

// File: rtl/dot_seq_ctrl.sv
// Sequencer for the dot-product unit: streams IN_CHUNKS buffer beats under
// dot_run, then waits (with a watchdog) for the unit's result and reports done.
module dot_seq_ctrl #(
  parameter int BIT_LENGTH = 16,
  parameter int DATA_N     = 6,
  parameter int HID_LENGTH = 24,
  parameter int IN_CHUNKS  = 8,
  parameter int AW         = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [AW-1:0]                    base_addr,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [HID_LENGTH*BIT_LENGTH-1:0] result,
  dot_seq_ctrl_if.master                   bus
);

  localparam int BW = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = HID_LENGTH * BIT_LENGTH;
  localparam int DW = DATA_N * BIT_LENGTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LAST,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          run_q, run_d;
  logic [RW-1:0] result_q, result_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      run_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      run_q    <= run_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    result_d = result_q;
    // The read-data buffers answer one cycle after rd_en, so the beat strobe lags by one.
    run_d    = (state_q == S_READ);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          beat_d  = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        addr_d = addr_q + AW'(1);
        beat_d = beat_q + BW'(1);
        if (beat_q == BW'(IN_CHUNKS - 1)) begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // A valid arriving on the final watchdog cycle still counts as an answer.
        if (bus.dot_valid) begin
          result_d = bus.dot_result;
          state_d  = S_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy           = (state_q == S_READ) || (state_q == S_LAST) || (state_q == S_WAIT);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign result         = result_q;
  assign bus.mem_rd_en  = (state_q == S_READ);
  assign bus.mem_addr   = addr_q;
  assign bus.dot_run    = run_q;
  assign bus.dot_data   = run_q ? bus.mem_data : {DW{1'b0}};
  assign bus.dot_weight = run_q ? bus.mem_wgt  : {DW{1'b0}};

endmodule
